// File: rtl/judge_demode_adapt.sv
// judge_demode_adapt: hysteresis slicer with a debounced output and
// envelope-tracking adaptive thresholds. Arithmetic uses DATA_W+1 bits
// internally, so envelope differences and sums never wrap.
module judge_demode_adapt #(
  parameter int DATA_W   = 14,
  parameter int DEB_N    = 8,
  parameter int DECAY_SH = 10,
  parameter int HYST_SH  = 3
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     judge_en,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic signed [DATA_W-1:0] up_judge_thre,
  input  logic signed [DATA_W-1:0] low_judge_thre,
  output logic                     bit_out,
  output logic        [DATA_W-1:0] data_out,
  output logic                     out_valid,
  output logic                     rise_pulse,
  output logic                     fall_pulse,
  output logic signed [DATA_W-1:0] up_eff,
  output logic signed [DATA_W-1:0] low_eff
);

  localparam int IW = DATA_W + 1;

  logic                     r_raw;
  logic                     r_valid_d1;
  logic                     r_bit;
  logic                     r_out_valid;
  logic                     r_rise;
  logic                     r_fall;
  logic [7:0]               r_cnt;
  logic signed [DATA_W-1:0] r_pk;
  logic signed [DATA_W-1:0] r_tr;
  logic signed [DATA_W-1:0] r_up_ad;
  logic signed [DATA_W-1:0] r_low_ad;

  logic signed [IW-1:0] w_din_x;
  logic signed [IW-1:0] w_up_x;
  logic signed [IW-1:0] w_low_x;
  logic signed [IW-1:0] w_pk_x;
  logic signed [IW-1:0] w_tr_x;
  logic signed [IW-1:0] w_span;
  logic signed [IW-1:0] w_decay;
  logic signed [IW-1:0] w_mid;
  logic signed [IW-1:0] w_hyst;
  logic                 w_above;
  logic                 w_below;

  // Fixed thresholds pass straight through; adaptive ones lag one accepted sample.
  assign up_eff  = mode ? r_up_ad  : up_judge_thre;
  assign low_eff = mode ? r_low_ad : low_judge_thre;

  assign w_din_x = {data_in[DATA_W-1], data_in};
  assign w_up_x  = {up_eff[DATA_W-1], up_eff};
  assign w_low_x = {low_eff[DATA_W-1], low_eff};
  assign w_pk_x  = {r_pk[DATA_W-1], r_pk};
  assign w_tr_x  = {r_tr[DATA_W-1], r_tr};

  assign w_span  = w_pk_x - w_tr_x;
  assign w_decay = w_span >>> DECAY_SH;
  assign w_mid   = (w_pk_x + w_tr_x) >>> 1;
  assign w_hyst  = w_span >>> HYST_SH;

  assign w_above = w_din_x > w_up_x;
  assign w_below = w_din_x < w_low_x;

  assign bit_out    = r_bit;
  assign data_out   = {DATA_W{r_bit}};
  assign out_valid  = r_out_valid;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

  // Hysteresis slicer; the upper compare wins if the thresholds are inverted.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_raw      <= 1'b0;
      r_valid_d1 <= 1'b0;
    end else if (!judge_en) begin
      r_raw      <= 1'b0;
      r_valid_d1 <= 1'b0;
    end else begin
      r_valid_d1 <= in_valid;
      if (in_valid) begin
        if (w_above)      r_raw <= 1'b1;
        else if (w_below) r_raw <= 1'b0;
      end
    end
  end

  // Debounce: bit_out follows raw only after DEB_N consecutive disagreeing samples.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt       <= 8'd0;
      r_bit       <= 1'b0;
      r_out_valid <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else if (!judge_en) begin
      r_cnt       <= 8'd0;
      r_bit       <= 1'b0;
      r_out_valid <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
    end else begin
      r_out_valid <= r_valid_d1;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      if (r_valid_d1) begin
        if (r_raw == r_bit) begin
          r_cnt <= 8'd0;
        end else if (r_cnt == 8'(DEB_N - 1)) begin
          r_bit  <= r_raw;
          r_cnt  <= 8'd0;
          r_rise <= r_raw;
          r_fall <= ~r_raw;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  // Peak/trough envelope: jump to new extremes, otherwise decay toward each other.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pk <= '0;
      r_tr <= '0;
    end else if (!judge_en) begin
      r_pk <= '0;
      r_tr <= '0;
    end else if (in_valid) begin
      if (w_din_x > w_pk_x) r_pk <= data_in;
      else                  r_pk <= DATA_W'(w_pk_x - w_decay);
      if (w_din_x < w_tr_x) r_tr <= data_in;
      else                  r_tr <= DATA_W'(w_tr_x + w_decay);
    end
  end

  // Adaptive thresholds: envelope midpoint plus/minus a fraction of its span.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_up_ad  <= '0;
      r_low_ad <= '0;
    end else if (in_valid && judge_en) begin
      r_up_ad  <= DATA_W'(w_mid + w_hyst);
      r_low_ad <= DATA_W'(w_mid - w_hyst);
    end
  end

endmodule

// File: tb/tb_judge_demode_adapt.sv
// Bench for judge_demode_adapt: expected decisions are queued per accepted
// sample and popped whenever the DUT raises out_valid.
module tb_judge_demode_adapt;

  localparam int W   = 14;
  localparam int DEB = 8;

  localparam logic signed [W-1:0] P300  = 14'sd300;
  localparam logic signed [W-1:0] N300  = -14'sd300;
  localparam logic signed [W-1:0] P100  = 14'sd100;
  localparam logic signed [W-1:0] NMIN  = 14'sh2000;
  localparam logic signed [W-1:0] P1000 = 14'sd1000;
  localparam logic signed [W-1:0] N1000 = -14'sd1000;
  localparam logic signed [W-1:0] P400  = 14'sd400;
  localparam logic signed [W-1:0] ZERO  = 14'sd0;

  logic                sys_clk = 1'b0;
  logic                sys_rst = 1'b0;
  logic                judge_en = 1'b0;
  logic                mode = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] data_in = '0;
  logic signed [W-1:0] up_thr = 14'sd200;
  logic signed [W-1:0] low_thr = -14'sd200;
  logic                bit_out;
  logic [W-1:0]        data_out;
  logic                out_valid;
  logic                rise_pulse;
  logic                fall_pulse;
  logic signed [W-1:0] up_eff;
  logic signed [W-1:0] low_eff;

  int n_checks = 0;
  int n_pass   = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int ov_cnt   = 0;

  bit exp_q[$];
  bit m_raw = 1'b0;
  bit m_bit = 1'b0;
  int m_cnt = 0;

  judge_demode_adapt #(.DATA_W(W), .DEB_N(DEB), .DECAY_SH(10), .HYST_SH(3)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .judge_en       (judge_en),
    .mode           (mode),
    .in_valid       (in_valid),
    .data_in        (data_in),
    .up_judge_thre  (up_thr),
    .low_judge_thre (low_thr),
    .bit_out        (bit_out),
    .data_out       (data_out),
    .out_valid      (out_valid),
    .rise_pulse     (rise_pulse),
    .fall_pulse     (fall_pulse),
    .up_eff         (up_eff),
    .low_eff        (low_eff)
  );

  always #5 sys_clk = ~sys_clk;

  // Scoreboard pop and pulse accounting, away from the active edge.
  always @(negedge sys_clk) begin
    bit e;
    if (!sys_rst) begin
      if (rise_pulse) rise_cnt++;
      if (fall_pulse) fall_cnt++;
      if (out_valid) begin
        ov_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_valid: out_valid=1 at %0t with no pending sample", $time);
        end else begin
          e = exp_q.pop_front();
          if (bit_out !== e || data_out !== {W{e}})
            $display("FAIL sb_decision: bit_out=%0b data_out=%h, required bit_out=%0b data_out=%h at %0t",
                     bit_out, data_out, e, {W{e}}, $time);
          else
            n_pass++;
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic signed [W-1:0] d);
    in_valid = v;
    data_in  = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, ZERO);
  endtask

  task automatic model_reset();
    m_raw = 1'b0;
    m_bit = 1'b0;
    m_cnt = 0;
  endtask

  // Fixed-threshold reference: slicer then debounce, one expectation per sample.
  task automatic sample_fixed(input logic signed [W-1:0] d);
    if (d > up_thr)       m_raw = 1'b1;
    else if (d < low_thr) m_raw = 1'b0;
    if (m_raw == m_bit) m_cnt = 0;
    else if (m_cnt == DEB - 1) begin
      m_bit = m_raw;
      m_cnt = 0;
    end else m_cnt++;
    exp_q.push_back(m_bit);
    cyc(1'b1, d);
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    judge_en = 1'b0;
    @(posedge sys_clk);
    #1;
    judge_en = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    mode = 1'b1;
    #1 sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #2;
    n_checks++;
    if ({bit_out, data_out, out_valid, rise_pulse, fall_pulse, up_eff, low_eff} !== '0)
      $display("FAIL reset_outputs: bit=%0b dout=%h ov=%0b rise=%0b fall=%0b up=%0d low=%0d, required all 0",
               bit_out, data_out, out_valid, rise_pulse, fall_pulse, up_eff, low_eff);
    else n_pass++;
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    mode = 1'b0;
    judge_en = 1'b1;
    model_reset();
  endtask

  task automatic test_signed();
    int r0;
    r0 = rise_cnt;
    repeat (20) sample_fixed(NMIN);
    idle(2);
    n_checks++;
    if (bit_out !== 1'b0) $display("FAIL signed_min_bit: bit_out=%0b, required 0", bit_out);
    else n_pass++;
    n_checks++;
    if (rise_cnt !== r0) $display("FAIL signed_min_rise: rises=%0d, required %0d", rise_cnt, r0);
    else n_pass++;
  endtask

  task automatic test_fixed();
    int r0;
    r0 = rise_cnt;
    repeat (7) sample_fixed(P300);
    sample_fixed(N300);
    idle(2);
    n_checks++;
    if (rise_cnt !== r0) $display("FAIL fixed_no_rise: rises=%0d, required %0d", rise_cnt, r0);
    else n_pass++;
    repeat (8) sample_fixed(P300);
    n_checks++;
    if (bit_out !== 1'b0) $display("FAIL fixed_latency_early: bit_out=%0b one cycle after 8th, required 0", bit_out);
    else n_pass++;
    cyc(1'b0, ZERO);
    n_checks++;
    if (bit_out !== 1'b1 || data_out !== 14'h3FFF)
      $display("FAIL fixed_flip: bit_out=%0b data_out=%h, required 1 / 3fff", bit_out, data_out);
    else n_pass++;
    idle(2);
    n_checks++;
    if (rise_cnt !== r0 + 1) $display("FAIL fixed_one_rise: rises=%0d, required %0d", rise_cnt, r0 + 1);
    else n_pass++;
  endtask

  task automatic test_hyst();
    int f0;
    f0 = fall_cnt;
    repeat (20) sample_fixed(P100);
    idle(2);
    n_checks++;
    if (bit_out !== 1'b1 || fall_cnt !== f0)
      $display("FAIL hyst_hold: bit_out=%0b falls=%0d, required 1 / %0d", bit_out, fall_cnt, f0);
    else n_pass++;
  endtask

  task automatic test_gating();
    int ov0;
    repeat (8) sample_fixed(N300);
    idle(2);
    n_checks++;
    if (bit_out !== 1'b0) $display("FAIL gate_pre_fall: bit_out=%0b, required 0", bit_out);
    else n_pass++;
    ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) begin
      sample_fixed(P300);
      if (i < 7) idle(3);
    end
    n_checks++;
    if (bit_out !== 1'b0) $display("FAIL gate_latency_early: bit_out=%0b, required 0", bit_out);
    else n_pass++;
    cyc(1'b0, ZERO);
    n_checks++;
    if (bit_out !== 1'b1) $display("FAIL gate_flip: bit_out=%0b, required 1", bit_out);
    else n_pass++;
    idle(3);
    n_checks++;
    if (ov_cnt !== ov0 + 8) $display("FAIL gate_valid_count: out_valid=%0d, required %0d", ov_cnt - ov0, 8);
    else n_pass++;
  endtask

  task automatic test_adaptive();
    int r0, f0, u, l;
    bit e;
    do_clear();
    mode = 1'b1;
    r0 = rise_cnt;
    f0 = fall_cnt;
    for (int s = 0; s < 2000; s++) begin
      e = (s >= 7) && ((((s - 7) / 32) % 2) == 0);
      exp_q.push_back(e);
      cyc(1'b1, (((s / 32) % 2) == 0) ? P1000 : N1000);
    end
    idle(2);
    u = up_eff;
    l = low_eff;
    n_checks++;
    if (u < 234 || u > 266) $display("FAIL adapt_up: up_eff=%0d, required 250+-16", u);
    else n_pass++;
    n_checks++;
    if (l < -266 || l > -234) $display("FAIL adapt_low: low_eff=%0d, required -250+-16", l);
    else n_pass++;
    n_checks++;
    if (rise_cnt - r0 !== 32) $display("FAIL adapt_rises: rises=%0d, required 32", rise_cnt - r0);
    else n_pass++;
    n_checks++;
    if (fall_cnt - f0 !== 31) $display("FAIL adapt_falls: falls=%0d, required 31", fall_cnt - f0);
    else n_pass++;
  endtask

  task automatic test_clear();
    int r0;
    do_clear();
    mode = 1'b0;
    repeat (8) sample_fixed(P300);
    idle(2);
    n_checks++;
    if (bit_out !== 1'b1) $display("FAIL clear_pre_bit: bit_out=%0b, required 1", bit_out);
    else n_pass++;
    repeat (5) sample_fixed(N300);
    idle(2);
    judge_en = 1'b0;
    @(posedge sys_clk);
    #1;
    n_checks++;
    if (bit_out !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL clear_bit: bit_out=%0b out_valid=%0b, required 0 / 0", bit_out, out_valid);
    else n_pass++;
    judge_en = 1'b1;
    model_reset();
    r0 = rise_cnt;
    repeat (7) sample_fixed(P300);
    idle(2);
    n_checks++;
    if (bit_out !== 1'b0) $display("FAIL clear_count_early: bit_out=%0b after 7, required 0", bit_out);
    else n_pass++;
    sample_fixed(P300);
    idle(2);
    n_checks++;
    if (bit_out !== 1'b1 || rise_cnt !== r0 + 1)
      $display("FAIL clear_count_flip: bit_out=%0b rises=%0d, required 1 / %0d", bit_out, rise_cnt - r0, 1);
    else n_pass++;
    // Envelope cleared: after two samples of 400 the thresholds reflect pk=400, tr=0.
    do_clear();
    mode = 1'b1;
    repeat (2) begin
      exp_q.push_back(1'b0);
      cyc(1'b1, P400);
    end
    idle(2);
    n_checks++;
    if (up_eff !== 14'sd250 || low_eff !== 14'sd150)
      $display("FAIL clear_envelope: up_eff=%0d low_eff=%0d, required 250 / 150", up_eff, low_eff);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_clear();
    mode = 1'b0;
    repeat (8) sample_fixed(P300);
    idle(2);
    n_checks++;
    if (bit_out !== 1'b1) $display("FAIL arst_pre_bit: bit_out=%0b, required 1", bit_out);
    else n_pass++;
    mode = 1'b1;
    #2 sys_rst = 1'b1;
    #1;
    n_checks++;
    if ({bit_out, data_out, out_valid, rise_pulse, fall_pulse, up_eff, low_eff} !== '0)
      $display("FAIL arst_outputs: bit=%0b dout=%h ov=%0b up=%0d low=%0d, required all 0 before edge",
               bit_out, data_out, out_valid, up_eff, low_eff);
    else n_pass++;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    exp_q.delete();
    model_reset();
    mode = 1'b0;
    repeat (8) sample_fixed(P300);
    idle(2);
    n_checks++;
    if (bit_out !== 1'b1) $display("FAIL arst_resume: bit_out=%0b after 8 samples, required 1", bit_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_signed();
    test_fixed();
    test_hyst();
    test_gating();
    test_adaptive();
    test_clear();
    test_async_reset();
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d expectations left, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
